// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO access port between two requesters; all outputs registered.
// Optional bus lock (atomic read-modify-write) is built only when MMIO_ARB_LOCK_EN is defined.
module mmio_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  access0,
  input  logic [2:0]  access1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        mmio_load,
  output logic        mmio_store,
  output logic [2:0]  mmio_access,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  input  logic [31:0] mmio_rdata,
  output logic        busy
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = (RD_LAT > 1) ? CW'(RD_LAT - 1) : '0;

  // IDLE: arbitrate | ISSUE: single load/store pulse | WAIT: read latency | RESP: ack
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ack0_nxt, ack1_nxt, load_nxt, store_nxt, busy_nxt;
  logic [2:0]    access_nxt;
  logic [31:0]   addr_nxt, wdata_nxt, rdata_nxt;
  logic          take, win, win_we, lock_hold;

`ifdef MMIO_ARB_LOCK_EN
  logic locked, locked_nxt;

  // A locked owner keeps the port only while it keeps requesting in IDLE.
  assign lock_hold = locked && (last_gnt ? req1 : req0);

  always_comb begin
    locked_nxt = locked;
    if (state == IDLE) locked_nxt = take && (win ? lock1 : lock0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) locked <= 1'b0;
    else      locked <= locked_nxt;
  end
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    take = req0 | req1;
    if (lock_hold)          win = last_gnt;
    else if (req0 && req1)  win = ~last_gnt;
    else                    win = req1;
    win_we = win ? we1 : we0;
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    cnt_nxt      = cnt;
    access_nxt   = mmio_access;
    addr_nxt     = mmio_addr;
    wdata_nxt    = mmio_wdata;
    rdata_nxt    = rdata;
    load_nxt     = 1'b0;
    store_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt    = ISSUE;
          last_gnt_nxt = win;
          access_nxt   = win ? access1 : access0;
          addr_nxt     = win ? addr1 : addr0;
          wdata_nxt    = win ? wdata1 : wdata0;
          load_nxt     = !win_we;
          store_nxt    = win_we;
        end
      end
      ISSUE: begin
        if (mmio_store) begin
          state_nxt = RESP;
          rdata_nxt = '0;
        end else if (RD_LAT == 0) begin
          state_nxt = RESP;
          rdata_nxt = mmio_rdata;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          rdata_nxt = mmio_rdata;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ack0_nxt = (state_nxt == RESP) && !last_gnt_nxt;
    ack1_nxt = (state_nxt == RESP) && last_gnt_nxt;
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      cnt         <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      mmio_load   <= 1'b0;
      mmio_store  <= 1'b0;
      busy        <= 1'b0;
      rdata       <= '0;
      mmio_access <= '0;
      mmio_addr   <= '0;
      mmio_wdata  <= '0;
    end else begin
      state       <= state_nxt;
      last_gnt    <= last_gnt_nxt;
      cnt         <= cnt_nxt;
      ack0        <= ack0_nxt;
      ack1        <= ack1_nxt;
      mmio_load   <= load_nxt;
      mmio_store  <= store_nxt;
      busy        <= busy_nxt;
      rdata       <= rdata_nxt;
      mmio_access <= access_nxt;
      mmio_addr   <= addr_nxt;
      mmio_wdata  <= wdata_nxt;
    end
  end

endmodule
